// File: rtl/cpu_dmem_responder_pkg.sv
// cpu_bus_pkg: shared constants and types for the CPU data-memory responder.
//   AW/DW     - address / data width of the data RAM (depth = 2**AW words)
//   CNT_ADDR  - read-only write-counter location
//   OUT_ADDR  - result mailbox location
//   RW_RD/RW_WR - encodings of the CPU RW strobe
//   state_t   - responder FSM states
package cpu_bus_pkg;

    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [AW-1:0] CNT_ADDR = AW'(126);
    localparam logic [AW-1:0] OUT_ADDR = AW'(127);

    localparam logic RW_RD = 1'b1;
    localparam logic RW_WR = 1'b0;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        HACK
    } state_t;

endpackage

// File: rtl/cpu_dmem_responder_if.sv
// cpu_dmem_responder_if: CPU data bus control lines plus the halted-only host
// load/peek port and status outputs of the data-memory responder.
//   DA/RW/HALT      - CPU address, read/write strobe, CPU-held flag
//   LREQ/LWE/LA/LD  - host request level, write flag, address, write data
//   LQ/LACK         - host read data and one-cycle acknowledge
//   BUSY/OUT/OV/DONE - clear in progress, mailbox value, mailbox pulse, sticky done
// The bidirectional DD data bus is a plain port on the responder.
interface cpu_dmem_responder_if
    import cpu_bus_pkg::*;
();

    logic [15:0]   DA;
    logic          RW;
    logic          HALT;
    logic          LREQ;
    logic          LWE;
    logic [AW-1:0] LA;
    logic [DW-1:0] LD;
    logic [DW-1:0] LQ;
    logic          LACK;
    logic          BUSY;
    logic [DW-1:0] OUT;
    logic          OV;
    logic          DONE;

    modport slave (
        input  DA, RW, HALT, LREQ, LWE, LA, LD,
        output LQ, LACK, BUSY, OUT, OV, DONE
    );

    modport master (
        output DA, RW, HALT, LREQ, LWE, LA, LD,
        input  LQ, LACK, BUSY, OUT, OV, DONE
    );

endinterface

// File: rtl/cpu_dmem_responder_dmem_ram.sv
// dmem_ram: single-port 2**AW x DW data array.
//   clk   - write clock (falling edge)
//   we    - write enable
//   addr  - shared read/write address
//   wdata - write data
//   rdata - asynchronous read data at addr
module dmem_ram
    import cpu_bus_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(negedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_dmem_responder.sv
// cpu_dmem_responder: memory-side responder for the CPU data bus.
//   CK  - clock, all state updates on the falling edge
//   RST - asynchronous active-low reset
//   DD  - CPU data bus, driven with the registered read data while RW=1 and HALT=0
//   bus - DA/RW/HALT, host load/peek port, BUSY/OUT/OV/DONE status
// After reset the RAM is zeroed one word per edge (BUSY high), then CPU
// accesses are serviced; with HALT=1 a host may read/write the RAM and the
// counter/mailbox registers with a level request / one-cycle ack handshake.
module cpu_dmem_responder
    import cpu_bus_pkg::*;
(
    input  logic             CK,
    input  logic             RST,
    inout  wire [DW-1:0]     DD,
    cpu_dmem_responder_if.slave bus
);

    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] lq_q;
    logic          lack_q;
    logic          busy_q;
    logic [DW-1:0] out_q;
    logic          ov_q;
    logic          done_q;
    logic [DW-1:0] wcnt;

    logic [AW-1:0] da;
    logic          unused_da_hi;
    logic          cpu_en;
    logic          host_go;
    logic          dd_oe;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] lq_mux;

    // Only the low AW address bits are decoded.
    assign da           = bus.DA[AW-1:0];
    assign unused_da_hi = ^bus.DA[15:AW];

    assign cpu_en  = (state != CLEAR) && !bus.HALT;
    assign host_go = (state == RUN) && bus.HALT && bus.LREQ;

    // The RAM has one address: clear pointer, host address while halted in
    // RUN, CPU address otherwise.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = da;
        ram_wdata = DD;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_ptr;
            ram_wdata = '0;
        end else if ((state == RUN) && bus.HALT) begin
            ram_addr  = bus.LA;
            ram_wdata = bus.LD;
            if (bus.LREQ && bus.LWE && (bus.LA != CNT_ADDR) && (bus.LA != OUT_ADDR)) begin
                ram_we = 1'b1;
            end
        end else if (cpu_en) begin
            // An unknown RW falls into the write branch.
            if (bus.RW == RW_RD) begin
                ram_we = 1'b0;
            end else if ((da != CNT_ADDR) && (da != OUT_ADDR)) begin
                ram_we = 1'b1;
            end
        end
    end

    always_comb begin
        case (da)
            CNT_ADDR: rd_mux = wcnt;
            OUT_ADDR: rd_mux = out_q;
            default:  rd_mux = ram_rdata;
        endcase
        case (bus.LA)
            CNT_ADDR: lq_mux = wcnt;
            OUT_ADDR: lq_mux = out_q;
            default:  lq_mux = ram_rdata;
        endcase
    end

    always_comb begin
        dd_oe = 1'b0;
        if (!bus.HALT && (bus.RW == RW_RD)) begin
            dd_oe = 1'b1;
        end
    end

    assign DD = dd_oe ? rd_q : 'z;

    dmem_ram u_ram (
        .clk   (CK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(negedge CK or negedge RST) begin
        if (!RST) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy_q  <= 1'b1;
            rd_q    <= '0;
            lq_q    <= '0;
            lack_q  <= 1'b0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
            wcnt    <= '0;
        end else begin
            ov_q   <= 1'b0;
            lack_q <= 1'b0;

            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (!bus.HALT && (bus.RW == RW_RD)) begin
                        rd_q <= '0;
                    end
                    if (clr_ptr == '1) begin
                        busy_q <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (host_go) begin
                        lack_q <= 1'b1;
                        state  <= HACK;
                        if (bus.LWE) begin
                            if (bus.LA == CNT_ADDR) begin
                                wcnt <= bus.LD;
                            end else if (bus.LA == OUT_ADDR) begin
                                out_q <= bus.LD;
                            end
                        end else begin
                            lq_q <= lq_mux;
                        end
                    end
                end
                HACK: begin
                    // Wait for the request to drop so each request gets one ack.
                    if (!bus.LREQ) begin
                        state <= RUN;
                    end
                end
                default: state <= CLEAR;
            endcase

            if (cpu_en) begin
                if (bus.RW == RW_RD) begin
                    rd_q <= rd_mux;
                end else if (da == OUT_ADDR) begin
                    out_q  <= DD;
                    ov_q   <= 1'b1;
                    done_q <= 1'b1;
                    wcnt   <= wcnt + DW'(1);
                end else if (da != CNT_ADDR) begin
                    wcnt <= wcnt + DW'(1);
                end
            end
        end
    end

    assign bus.LQ   = lq_q;
    assign bus.LACK = lack_q;
    assign bus.BUSY = busy_q;
    assign bus.OUT  = out_q;
    assign bus.OV   = ov_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// tb_cpu_dmem_responder: directed self-checking bench for cpu_dmem_responder.
// Inputs change 1 time unit after the rising edge; the DUT updates on the
// falling edge, and outputs are checked 1 time unit after the next rising edge.
module tb_cpu_dmem_responder;
    import cpu_bus_pkg::*;

    logic        CK  = 1'b1;
    logic        RST = 1'b1;
    logic        dd_oe;
    logic [15:0] dd_drv;
    wire  [15:0] DD;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned n;
    int unsigned acks;

    assign DD = dd_oe ? dd_drv : 'z;

    cpu_dmem_responder_if bus ();

    cpu_dmem_responder dut (
        .CK  (CK),
        .RST (RST),
        .DD  (DD),
        .bus (bus)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        bus.RW = RW_RD;
        bus.DA = a;
        dd_oe  = 1'b0;
        step();
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        bus.RW = RW_WR;
        bus.DA = a;
        dd_drv = d;
        dd_oe  = 1'b1;
        step();
        bus.RW = RW_RD;
        dd_oe  = 1'b0;
    endtask

    task automatic host(input logic we, input logic [6:0] a, input logic [15:0] d);
        bus.LREQ = 1'b1;
        bus.LWE  = we;
        bus.LA   = a;
        bus.LD   = d;
        step();
    endtask

    task automatic host_rel();
        bus.LREQ = 1'b0;
        step();
    endtask

    task automatic wait_clear(output int unsigned cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (bus.BUSY && cnt < 300);
    endtask

    initial begin
        bus.HALT = 1'b0;
        bus.RW   = RW_RD;
        bus.DA   = 16'h0000;
        bus.LREQ = 1'b0;
        bus.LWE  = 1'b0;
        bus.LA   = 7'd0;
        bus.LD   = 16'h0000;
        dd_oe    = 1'b0;
        dd_drv   = 16'h0000;
        #1 RST = 1'b0;
        #1;
        checkb("rst_busy", bus.BUSY, 1'b1);
        checkb("rst_lack", bus.LACK, 1'b0);
        check ("rst_out",  bus.OUT, 16'h0000);
        checkb("rst_ov",   bus.OV, 1'b0);
        checkb("rst_done", bus.DONE, 1'b0);
        step();
        RST = 1'b1;

        // First clear edge carries a CPU write that must be dropped.
        bus.RW = RW_WR; bus.DA = 16'd3; dd_drv = 16'h1234; dd_oe = 1'b1;
        step();
        n = 1;
        bus.RW = RW_RD; dd_oe = 1'b0; bus.DA = 16'd5;
        while (bus.BUSY && n < 300) begin
            step();
            n++;
        end
        check("clear_len", 16'(n), 16'd128);

        cpu_rd(16'd5);   check("rd5_zero", DD, 16'h0000);
        cpu_rd(16'd3);   check("rd3_dropped", DD, 16'h0000);
        cpu_rd(16'd126); check("cnt_zero", DD, 16'h0000);

        cpu_wr(16'd0, 16'h0004);
        cpu_rd(16'd0);   check("rd0", DD, 16'h0004);
        cpu_rd(16'd126); check("cnt_1", DD, 16'h0001);

        cpu_wr(16'd127, 16'h0004);
        check ("mb_out1", bus.OUT, 16'h0004);
        checkb("mb_ov1", bus.OV, 1'b1);
        checkb("mb_done1", bus.DONE, 1'b1);
        cpu_rd(16'd0);
        checkb("mb_ov_pulse", bus.OV, 1'b0);
        cpu_wr(16'd127, 16'h0009);
        check ("mb_out2", bus.OUT, 16'h0009);
        checkb("mb_done2", bus.DONE, 1'b1);
        cpu_wr(16'd126, 16'hFFFF);
        cpu_rd(16'd126); check("cnt_3_ro", DD, 16'h0003);
        cpu_wr(16'h0085, 16'hBEEF);
        cpu_rd(16'd5);   check("da_hi_ignored", DD, 16'hBEEF);
        cpu_rd(16'd127); check("rd_out", DD, 16'h0009);

        // Halted: the DUT must release DD even with RW=1 (rd_q holds 0x0009).
        bus.HALT = 1'b1; dd_drv = 16'h0000; dd_oe = 1'b1;
        step();
        check("halt_dd_z", DD, 16'h0000);

        bus.LREQ = 1'b1; bus.LWE = 1'b1; bus.LA = 7'd1; bus.LD = 16'd50;
        acks = 0;
        repeat (3) begin
            step();
            acks += 32'(bus.LACK);
        end
        bus.LREQ = 1'b0;
        step();
        acks += 32'(bus.LACK);
        check("single_ack", 16'(acks), 16'd1);
        check("halt_dd_z2", DD, 16'h0000);

        host(1'b0, 7'd1, 16'h0000);
        checkb("hrd_lack", bus.LACK, 1'b1);
        check ("hrd_lq1", bus.LQ, 16'd50);
        host_rel();
        host(1'b0, 7'd126, 16'h0000);
        check("hrd_cnt", bus.LQ, 16'h0004);
        host_rel();
        host(1'b1, 7'd126, 16'h0100);
        host_rel();
        host(1'b0, 7'd126, 16'h0000);
        check("hrd_cnt_load", bus.LQ, 16'h0100);
        host_rel();
        host(1'b1, 7'd127, 16'h0077);
        check ("hwr_out", bus.OUT, 16'h0077);
        checkb("hwr_no_ov", bus.OV, 1'b0);
        checkb("hwr_done", bus.DONE, 1'b1);
        host_rel();

        bus.HALT = 1'b0; dd_oe = 1'b0;
        cpu_rd(16'd126); check("cpu_cnt_load", DD, 16'h0100);
        cpu_rd(16'd1);   check("cpu_rd_host", DD, 16'd50);
        cpu_rd(16'd127); check("cpu_rd_hout", DD, 16'h0077);

        // HALT drops while in HACK: CPU serviced, no second ack until LREQ falls.
        bus.HALT = 1'b1;
        host(1'b0, 7'd1, 16'h0000);
        checkb("hack_lack", bus.LACK, 1'b1);
        bus.HALT = 1'b0;
        cpu_wr(16'd2, 16'h0055);
        checkb("hack_lack_low", bus.LACK, 1'b0);
        cpu_rd(16'd2);   check("hack_cpu_rd", DD, 16'h0055);
        bus.HALT = 1'b1;
        step();
        checkb("hack_no_reack", bus.LACK, 1'b0);
        bus.LREQ = 1'b0;
        step();
        bus.LREQ = 1'b1;
        step();
        checkb("hack2_lack", bus.LACK, 1'b1);

        // Reset during the handshake.
        RST = 1'b0;
        #1;
        checkb("rst_hack_lack", bus.LACK, 1'b0);
        checkb("rst_hack_busy", bus.BUSY, 1'b1);
        check ("rst_hack_out", bus.OUT, 16'h0000);
        checkb("rst_hack_done", bus.DONE, 1'b0);
        bus.LREQ = 1'b0; bus.HALT = 1'b0; bus.RW = RW_RD; bus.DA = 16'd0;
        step();
        RST = 1'b1;
        wait_clear(n);
        check("clear_len2", 16'(n), 16'd128);

        // Reset in the middle of clearing restarts the full sequence.
        RST = 1'b0;
        step();
        RST = 1'b1;
        repeat (60) step();
        checkb("mid_clear_busy", bus.BUSY, 1'b1);
        RST = 1'b0;
        step();
        RST = 1'b1;
        wait_clear(n);
        check("clear_len3", 16'(n), 16'd128);

        cpu_rd(16'd2);   check("post_clr_rd2", DD, 16'h0000);
        cpu_rd(16'd126); check("post_clr_cnt", DD, 16'h0000);
        cpu_rd(16'd127); check("post_clr_out", DD, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
